dm_param: RTL

- Parametrised successor to the single-port data memory: configurable word width, depth and address width, with per-byte write enables.
- Read is registered with 1-cycle latency and a valid strobe.
- A hardware init sequencer fills every word with FILL_VALUE after reset or on request; accesses are rejected while it runs.
- Out-of-range accesses raise a sticky fault flag. Sits on the CPU datapath in place of the fixed 16-bit data memory.

---
 rtl/dm_param.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dm_param.sv
// -----------------------------------------------------------------------------
// dm_param -- parametrised single-port data memory with byte-lane writes,
// registered 1-cycle read, hardware fill sequencer and a sticky fault flag.
//
// Parameters
//   DATA_W      word width in bits (multiple of 8)
//   ADDR_W      address width in bits
//   DEPTH       number of words (DEPTH <= 2**ADDR_W)
//   FILL_VALUE  word written everywhere by the fill sequencer
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   init_req   one-cycle pulse: (re)start a fill of the whole array
//   addr       word address shared by read and write
//   din        write data
//   we         write enable
//   be         byte-lane enables, bit i covers din[8i+7:8i]
//   re         read enable
//   dout       registered read data (holds when no read is issued)
//   rvalid     dout carries the result of a read issued last cycle
//   busy       fill sequencer active, accesses are rejected
//   fault      sticky: out-of-range access, or access while busy
//   fault_clr  clears fault (a simultaneous new fault wins)
// -----------------------------------------------------------------------------
module dm_param #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 8,
  parameter int                DEPTH      = 256,
  parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_req,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  re,
  output logic [DATA_W-1:0]     dout,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  fault,
  input  logic                  fault_clr
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**ADDR_W is representable and never faults.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_rvalid;
  logic              r_busy;
  logic              r_fault;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_run;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_wr_en;
  logic              w_fault_ev;

  assign w_run      = (r_state == ST_RUN);
  assign w_in_range = ({1'b0, addr} < DEPTH_X);
  assign w_idx      = addr[IDX_W-1:0];
  // Only consumed when w_in_range is true, so aliasing of low index bits
  // for out-of-range addresses never reaches the array or dout.
  assign w_word     = r_mem[w_idx];

  always_comb begin
    w_merged = w_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) w_merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Write-first: a same-cycle write to the read address is visible in dout.
  assign w_rd_word  = we ? w_merged : w_word;
  assign w_wr_en    = w_run && we && w_in_range;
  assign w_fault_ev = (we || re) && (!w_run || !w_in_range);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_INIT;
      r_ptr    <= '0;
      r_busy   <= 1'b1;
      r_dout   <= '0;
      r_rvalid <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_rvalid <= 1'b0;
          if (init_req) begin
            r_ptr <= '0;
          end else if (r_ptr == LAST_IDX) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          if (init_req) begin
            r_state <= ST_INIT;
            r_busy  <= 1'b1;
            r_ptr   <= '0;
          end
          r_rvalid <= re;
          if (re) r_dout <= w_in_range ? w_rd_word : '0;
        end
      endcase

      if (w_fault_ev)     r_fault <= 1'b1;
      else if (fault_clr) r_fault <= 1'b0;
    end
  end

  // Array has no reset; the fill sequencer is what initialises it.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_ptr] <= FILL_VALUE;
    end else if (w_wr_en) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign dout   = r_dout;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign fault  = r_fault;

endmodule
